// File: rtl/request_unit_pipe_pkg.sv
// Shared types for the pipelined request unit: FSM state encoding and default widths.
package request_unit_pipe_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DATA  = 2'd1,
    HALT  = 2'd2
  } reqstate_t;

  localparam int WORD_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

endpackage

// File: rtl/request_unit_pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; used as the data-stall watchdog.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 200
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != WIDTH'(MAX))) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count  = count_reg;
  assign at_max = (count_reg == WIDTH'(MAX));

endmodule

// File: rtl/request_unit_pipe.sv
// Sequences instruction fetch and data-memory requests, holds the data request stable
// until dhit, gates PC advance, halts after draining, and watches for stalled data accesses.
module request_unit_pipe
  import request_unit_pipe_pkg::*;
#(
  parameter int WORD_W   = WORD_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200,
  parameter int CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              halt,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [ADDR_W-1:0] daddr_in,
  input  logic [WORD_W-1:0] dstore_in,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic [ADDR_W-1:0] daddr,
  output logic [WORD_W-1:0] dstore,
  output logic              pcenable,
  output logic              halted,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  dreq_count
);

  reqstate_t         state_reg, state_next;
  logic [ADDR_W-1:0] daddr_reg;
  logic [WORD_W-1:0] dstore_reg;
  logic              wr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              err_reg;

  logic              issue, done, wait_clr, wait_inc, at_max;
  logic [WAIT_W-1:0] wait_count;

  sat_counter #(
    .WIDTH (WAIT_W),
    .MAX   (MAX_WAIT)
  ) u_wait (
    .CLK    (CLK),
    .nRST   (nRST),
    .clr    (wait_clr),
    .inc    (wait_inc),
    .count  (wait_count),
    .at_max (at_max)
  );

  always_comb begin
    state_next = state_reg;
    iREN       = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    pcenable   = 1'b0;
    halted     = 1'b0;
    issue      = 1'b0;
    done       = 1'b0;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;
    case (state_reg)
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          // Halt wins over a simultaneous load/store.
          if (halt) begin
            state_next = HALT;
          end else if (memread || memwrite) begin
            issue      = 1'b1;
            wait_clr   = 1'b1;
            state_next = DATA;
          end else begin
            pcenable = 1'b1;
          end
        end
      end
      DATA: begin
        dWEN = wr_reg;
        dREN = ~wr_reg;
        if (dhit) begin
          pcenable   = 1'b1;
          done       = 1'b1;
          state_next = FETCH;
        end else begin
          wait_inc = 1'b1;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg  <= FETCH;
      daddr_reg  <= '0;
      dstore_reg <= '0;
      wr_reg     <= 1'b0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (issue) begin
        daddr_reg  <= daddr_in;
        dstore_reg <= dstore_in;
        wr_reg     <= memwrite;
      end
      if (done) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      err_reg <= err_reg | at_max;
    end
  end

  // at_max is OR'd in so the flag is visible in the very cycle the stall limit is reached.
  assign timeout_err = err_reg | at_max;
  assign daddr       = daddr_reg;
  assign dstore      = dstore_reg;
  assign dreq_count  = cnt_reg;

endmodule

// File: tb/tb_request_unit_pipe.sv
// Directed plus randomized bench for request_unit_pipe against a cycle-level reference model.
module tb_request_unit_pipe;

  localparam int MAXW = 4;

  logic        CLK = 1'b0;
  logic        nRST, memread, memwrite, halt, ihit, dhit;
  logic [31:0] daddr_in, dstore_in;
  logic        iREN, dREN, dWEN, pcenable, halted, timeout_err;
  logic [31:0] daddr, dstore;
  logic [15:0] dreq_count;

  always #5 CLK = ~CLK;

  request_unit_pipe #(
    .WORD_W(32), .ADDR_W(32), .WAIT_W(8), .MAX_WAIT(MAXW), .CNT_W(16)
  ) dut (
    .CLK(CLK), .nRST(nRST), .memread(memread), .memwrite(memwrite), .halt(halt),
    .ihit(ihit), .dhit(dhit), .daddr_in(daddr_in), .dstore_in(dstore_in),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .pcenable(pcenable), .halted(halted), .timeout_err(timeout_err),
    .dreq_count(dreq_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 = fetching, 1 = data access outstanding, 2 = halted.
  int          m_mode = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_store = '0;
  bit          m_wr = 1'b0;
  int          m_stall = 0;
  bit          m_err = 1'b0;
  int          m_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rst_n, input bit ih, input bit dh, input bit mr, input bit mw,
                      input bit hl, input logic [31:0] a, input logic [31:0] s, input bit chk);
    bit op;
    nRST = rst_n; ihit = ih; dhit = dh; memread = mr; memwrite = mw; halt = hl;
    daddr_in = a; dstore_in = s;
    op = mr | mw;
    @(negedge CLK);
    if (chk) begin
      check("iREN",     64'(iREN),     64'(m_mode == 0));
      check("dREN",     64'(dREN),     64'(m_mode == 1 && !m_wr));
      check("dWEN",     64'(dWEN),     64'(m_mode == 1 && m_wr));
      check("halted",   64'(halted),   64'(m_mode == 2));
      check("pcenable", 64'(pcenable),
            64'((m_mode == 0 && ih && !hl && !op) || (m_mode == 1 && dh)));
      check("daddr",    64'(daddr),    64'(m_addr));
      check("dstore",   64'(dstore),   64'(m_store));
      check("timeout",  64'(timeout_err), 64'(m_err || m_stall == MAXW));
      check("count",    64'(dreq_count), 64'(m_cnt % 65536));
    end
    @(posedge CLK);
    if (!rst_n) begin
      if (m_mode != 0) $display("txn: reset from mode %0d", m_mode);
      m_mode = 0; m_addr = '0; m_store = '0; m_wr = 0; m_stall = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (m_stall == MAXW) m_err = 1'b1;
      case (m_mode)
        0: if (ih) begin
          if (hl) begin
            m_mode = 2;
            $display("txn: halt");
          end else if (op) begin
            m_mode = 1; m_addr = a; m_store = s; m_wr = mw; m_stall = 0;
          end
        end
        1: if (dh) begin
          m_cnt++;
          m_mode = 0;
          $display("txn: %s addr=%08h data=%08h count=%0d", m_wr ? "store" : "load",
                   m_addr, m_store, m_cnt);
        end else if (m_stall < MAXW) begin
          m_stall++;
        end
        default: ;
      endcase
    end
    #1;
  endtask

  initial begin
    // Reset; first cycle unchecked since the DUT is uninitialised.
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    // Plain fetches.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    // Load with address changing after issue, dhit after 4 cycles.
    step(1, 1, 0, 1, 0, 0, 32'h0000_0040, 32'h0, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 0, 32'hDEAD_BEEF, 32'h1, 1);
    step(1, 0, 1, 0, 0, 0, 32'hDEAD_BEEF, 32'h1, 1);
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    // Store with both read and write set.
    step(1, 1, 0, 1, 1, 0, 32'h0000_0080, 32'h1234_5678, 1);
    step(1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 1);
    step(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    // Watchdog: 10 stalled cycles, then completion.
    step(1, 1, 0, 1, 0, 0, 32'h0000_0100, 32'h0, 1);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 1, 32'h0, 32'h0, 1);
    step(1, 0, 1, 0, 0, 0, 32'h0, 32'h0, 1);
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    // Halt, then spurious hits, then reset out of halt.
    step(1, 1, 0, 1, 0, 1, 32'h0, 32'h0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0, 0, 32'h0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    // Reset while a store is outstanding.
    step(1, 1, 0, 0, 1, 0, 32'h0000_0200, 32'hCAFE_F00D, 1);
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0),
           $urandom, $urandom, 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/request_unit_pipe.md
Name: request_unit_pipe

Overview:
- Parametrised successor to the single-cycle request unit. It sequences instruction-fetch and data-memory requests from the datapath to the memory controller.
- Latches the data address and store data at issue and holds them stable for the whole data transaction.
- Gates PC advance, performs an orderly halt after any in-flight data access drains, counts data transactions, and raises a sticky watchdog error when a data access stalls too long.
- Sits between the datapath (control unit, PC) and the memory-controller cache interface.

Parameters:
- WORD_W, 32, width of data words and store data.
- ADDR_W, 32, width of data address.
- WAIT_W, 8, width of the data-wait watchdog counter.
- MAX_WAIT, 200, number of stall cycles in DATA after which timeout_err sets. Must be < 2**WAIT_W.
- CNT_W, 16, width of the completed-data-transaction counter.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  synchronous active-low reset, sampled on CLK rising edge
- memread  in  1  current instruction loads
- memwrite  in  1  current instruction stores
- halt  in  1  current instruction is HALT
- ihit  in  1  instruction word valid this cycle
- dhit  in  1  data access complete this cycle
- daddr_in  in  ADDR_W  data address from ALU
- dstore_in  in  WORD_W  store data from register file
- iREN  out  1  instruction read enable
- dREN  out  1  data read enable
- dWEN  out  1  data write enable
- daddr  out  ADDR_W  latched data address
- dstore  out  WORD_W  latched store data
- pcenable  out  1  advance PC this cycle
- halted  out  1  block is halted
- timeout_err  out  1  sticky watchdog flag
- dreq_count  out  CNT_W  completed data transactions, wraps

Behaviour:
- Reset: all registered state is set on a CLK edge with nRST=0, including when a data access is in flight.
  - state=FETCH, daddr=0, dstore=0, write flag=0, wait counter=0, dreq_count=0, timeout_err=0, halted=0.
  - The in-flight access is dropped: dREN/dWEN deassert the cycle after the reset edge.
- Decode rule: a data op is memread|memwrite. If both are set, the access is a write.
- FETCH state:
  - iREN=1, dREN=dWEN=0.
  - ihit=1 and halt=1: pcenable=0, next state HALT. Halt takes priority over memread/memwrite.
  - ihit=1 and data op:
    - pcenable=0.
    - On the clock edge, latch daddr←daddr_in, dstore←dstore_in, write flag←memwrite.
    - Clear the wait counter; next state DATA.
  - ihit=1, no data op, no halt: pcenable=1, stay in FETCH.
  - ihit=0: pcenable=0, stay in FETCH.
- DATA state:
  - iREN=0.
  - dWEN=write flag, dREN=~write flag. These are held unconditionally until dhit.
  - daddr and dstore hold their latched values regardless of daddr_in/dstore_in changes.
  - dhit=1: pcenable=1 combinationally in the same cycle, dreq_count increments (modulo 2**CNT_W), next state FETCH.
  - dhit=0: pcenable=0, and the wait counter increments, saturating at MAX_WAIT.
  - When the counter equals MAX_WAIT, timeout_err sets. It stays set until reset. The request continues to be held; there is no abort.
  - halt input is ignored in DATA. A HALT is only recognised in FETCH, so any in-flight access always completes before halting.
- HALT state:
  - iREN=dREN=dWEN=0, pcenable=0, halted=1.
  - Terminal; exited only by reset.
- Output timing:
  - iREN, dREN, dWEN and halted are functions of state only (Moore).
  - pcenable is Mealy on ihit/dhit.
  - A one-cycle dhit yields exactly one pcenable pulse and exactly one dreq_count increment.
- Back-to-back data ops:
  - After DATA→FETCH there is at least one FETCH cycle with dREN=dWEN=0.
  - The next data op is issued only on a fresh ihit.
- Spurious inputs: dhit in FETCH or HALT is ignored (no count, no pcenable). ihit in DATA is ignored.

Decomposition:
- cpu_types_pkg gains:
  - enum reqstate_t {FETCH, DATA, HALT}, 2 bits.
  - Default constants for WORD_W/ADDR_W.
- request_unit_if extends to carry the new ports: halt, daddr/dstore in and out, halted, timeout_err, dreq_count.
- One sub-module, sat_counter (parameters WIDTH, MAX; ports clr, inc, count, at_max), implements the watchdog counter.
- dreq_count stays inline as a plain wrapping counter.

Test Plan:
- Reset then ihit=1, no data op, for 3 cycles → iREN=1, pcenable=1 each cycle, dREN=dWEN=0, dreq_count=0.
- Load: ihit=1, memread=1, daddr_in=0x0000_0040. Next cycle daddr_in changes to 0xDEAD_BEEF; dhit after 4 cycles → daddr=0x40 throughout DATA, dREN=1 for 4 cycles, pcenable pulses once with dhit, dreq_count=1.
- Store with memread=memwrite=1, dstore_in=0x1234_5678, dhit next cycle → dWEN=1, dREN=0, dstore=0x1234_5678, then return to FETCH with iREN=1.
- Watchdog: MAX_WAIT=4, memread issued, dhit held low 10 cycles → timeout_err=1 from the 5th DATA cycle onward. It stays 1 after a later dhit; dREN stays 1 until that dhit.
- Halt: halt=1 with ihit in FETCH → halted=1 next cycle, all enables 0. Later ihit/dhit pulses cause no pcenable and no count. Then nRST=0 for one edge → state FETCH, iREN=1, halted=0.
- Reset mid-DATA: memwrite issued, nRST=0 before dhit → cycle after the edge shows dWEN=0, iREN=1, daddr=0, dreq_count=0, timeout_err=0.
